cc_lookup_dispatch: RTL and testbench
=====================================

Name: cc_lookup_dispatch

Overview:
- Dispatch stage directly upstream of the cache-controller data reorder unit.
- Consumes one tag-lookup result per handshake from the tag-compare stage. Every lookup pushes its hit/miss flag, in request order, into the reorder unit's hit-flag FIFO.
- Hits also push {offset, 512-bit line} into the hit-data FIFO.
- Misses issue a 64-byte wrap burst on the memory AXI AR channel; the returning R data is consumed by the reorder unit.

Parameters:
ADDR_WIDTH, 32, request address width
MAX_OUTSTANDING, 4, maximum misses issued but not yet completed (R last beat seen)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
lkup_valid_i  input  1  lookup result valid
lkup_ready_o  output  1  lookup accepted when valid & ready
lkup_hit_i  input  1  1 = tag hit
lkup_addr_i  input  ADDR_WIDTH  request byte address
lkup_data_i  input  512  data-SRAM line (meaningful on hit only)
hit_flag_fifo_afull_i  input  1  hit-flag FIFO almost full
hit_flag_fifo_wren_o  output  1  hit-flag FIFO write enable
hit_flag_fifo_wdata_o  output  1  flag (1 = hit)
hit_data_fifo_afull_i  input  1  hit-data FIFO almost full
hit_data_fifo_wren_o  output  1  hit-data FIFO write enable
hit_data_fifo_wdata_o  output  518  {addr[5:0], line[511:0]}
mem_araddr_o  output  ADDR_WIDTH  {addr[ADDR_WIDTH-1:3], 3'b000}
mem_arlen_o  output  4  constant 4'd7
mem_arsize_o  output  3  constant 3'b011 (8 B)
mem_arburst_o  output  2  constant 2'b10 (WRAP)
mem_arvalid_o  output  1  AR valid
mem_arready_i  input  1  AR ready
mem_rvalid_i  input  1  R-channel snoop: valid
mem_rready_i  input  1  R-channel snoop: ready (driven by the reorder unit)
mem_rlast_i  input  1  R-channel snoop: last

Behaviour:
- Reset: all wren_o = 0; wdata_o = 0; mem_arvalid_o = 0; mem_araddr_o = 0; miss counter = 0; AR FSM = AR_IDLE.
- While rst_n is low, lkup_ready_o = 0.
- ar_free = (AR FSM == AR_IDLE) | (mem_arvalid_o & mem_arready_i).
- lkup_ready_o is combinational, and depends on lkup_hit_i as payload, not on lkup_valid_i:
  - Hit: lkup_ready_o = !hit_flag_fifo_afull_i & !hit_data_fifo_afull_i.
  - Miss: lkup_ready_o = !hit_flag_fifo_afull_i & ar_free & (miss_cnt < MAX_OUTSTANDING).
- Accepted lookup, registered, one-cycle latency:
  - Next cycle hit_flag_fifo_wren_o = 1 and wdata = lkup_hit_i.
  - On a hit, hit_data_fifo_wren_o = 1 in the same cycle as the flag write.
  - Otherwise both wren_o = 0.
  - Flag order equals acceptance order.
- FIFO sizing: because writes lag acceptance by one cycle, afull thresholds must leave at least one free entry. Here that means hit-flag FIFO afull at DEPTH-1 and hit-data FIFO afull at DEPTH-1 or lower.
- AR FSM:
  - AR_IDLE -> AR_VALID on an accepted miss; mem_araddr_o is loaded and mem_arvalid_o = 1 from the next cycle.
  - AR_VALID -> AR_IDLE on arready, unless a new miss is accepted in the same cycle; then it stays in AR_VALID and loads the new address.
  - araddr/arvalid hold stable until arready.
  - The wrap burst returns the critical 8-byte word first.
- Miss counter, width $clog2(MAX_OUTSTANDING+1):
  - +1 on accepted miss.
  - -1 on mem_rvalid_i & mem_rready_i & mem_rlast_i.
  - Both in one cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING. An rlast beat while the count is 0 is a protocol error: flag it with an assertion and saturate at 0.
- Reset mid-operation (synchronous, takes priority):
  - Drops a pending AR, clears counters, and suppresses the pending FIFO write.
  - The system must reset the FIFOs and memory in the same cycle.
- Back-to-back hits sustain one lookup per cycle.
- Back-to-back misses sustain one per cycle only while arready stays high.

Decomposition:
- cc_pkg holds:
  - CC_LINE_W = 512, CC_OFFSET_W = 6, CC_HIT_DATA_W = 518.
  - CC_AR_LEN = 4'd7, CC_AR_SIZE = 3'b011, CC_AR_BURST_WRAP = 2'b10.
  - typedef enum {AR_IDLE, AR_VALID} cc_ar_state_e.
- One natural sub-module, cc_miss_ar_issue: the AR FSM, address register and outstanding-miss counter. It exports ar_free and cnt_ok.
- The top level keeps the ready logic and the FIFO write registers.

Test Plan:
- Hit at addr 0x0000_1028, line = 0xAA..AA, FIFOs empty -> next cycle flag wren = 1 / wdata = 1, data wren = 1 / wdata = {6'h28, 512'hAA..AA}; arvalid stays 0.
- Miss at 0x0000_2034, arready = 1 -> next cycle flag wdata = 0, arvalid = 1, araddr = 0x0000_2030, arlen = 7, arburst = WRAP; miss_cnt = 1.
- Sequence hit, miss, hit, miss -> flag FIFO sees 1, 0, 1, 0 in order; data FIFO gets exactly 2 writes.
- 5 misses, arready = 1, no rlast -> the 5th is held (ready = 0); one rlast beat -> the 5th is accepted next cycle.
- Miss with arready = 0 for 3 cycles -> araddr/arvalid stable; a second miss is blocked until the arready cycle; then it is accepted in that same cycle and AR stays valid with the new address.
- hit_data_fifo_afull = 1 with a hit pending -> ready = 0, no writes; a miss offered instead is accepted; rst_n = 0 with AR pending -> arvalid = 0 the next cycle, miss_cnt = 0.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared constants and types for the cache-controller lookup dispatch stage.
package cc_pkg;

    localparam int CC_LINE_W     = 512;
    localparam int CC_OFFSET_W   = 6;
    localparam int CC_HIT_DATA_W = CC_OFFSET_W + CC_LINE_W;

    localparam logic [3:0] CC_AR_LEN        = 4'd7;
    localparam logic [2:0] CC_AR_SIZE       = 3'b011;
    localparam logic [1:0] CC_AR_BURST_WRAP = 2'b10;

    typedef enum logic {
        AR_IDLE  = 1'b0,
        AR_VALID = 1'b1
    } cc_ar_state_e;

endpackage

// File: rtl/cc_miss_ar_issue.sv
// Miss issue path: AR channel FSM, held address register and outstanding-miss counter.
module cc_miss_ar_issue
    import cc_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_accept,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  arready,
    input  logic                  rvalid,
    input  logic                  rready,
    input  logic                  rlast,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    output logic                  ar_free,
    output logic                  cnt_ok
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    cc_ar_state_e     state;
    logic [CNT_W-1:0] miss_cnt;
    logic             rlast_beat;

    assign rlast_beat = rvalid & rready & rlast;
    assign ar_free    = (state == AR_IDLE) | (arvalid & arready);
    assign cnt_ok     = miss_cnt < CNT_W'(MAX_OUTSTANDING);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= AR_IDLE;
            arvalid  <= 1'b0;
            araddr   <= '0;
            miss_cnt <= '0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (miss_accept) begin
                        state   <= AR_VALID;
                        arvalid <= 1'b1;
                        araddr  <= miss_addr;
                    end
                end
                AR_VALID: begin
                    // A miss is only accepted here when arready completes the current request.
                    if (arready) begin
                        if (miss_accept) begin
                            araddr <= miss_addr;
                        end else begin
                            state   <= AR_IDLE;
                            arvalid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= AR_IDLE;
                    arvalid <= 1'b0;
                end
            endcase

            case ({miss_accept, rlast_beat})
                2'b10:   miss_cnt <= miss_cnt + CNT_W'(1);
                2'b01:   if (miss_cnt != '0) miss_cnt <= miss_cnt - CNT_W'(1);
                default: miss_cnt <= miss_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && rlast_beat) begin
            assert (miss_cnt != '0)
            else $error("rlast beat seen with no outstanding miss");
        end
    end

endmodule

// File: rtl/cc_lookup_dispatch.sv
// Routes tag-lookup results: flag per lookup, line data on hits, wrap-burst AR on misses.
module cc_lookup_dispatch
    import cc_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lkup_valid_i,
    output logic                     lkup_ready_o,
    input  logic                     lkup_hit_i,
    input  logic [ADDR_WIDTH-1:0]    lkup_addr_i,
    input  logic [CC_LINE_W-1:0]     lkup_data_i,
    input  logic                     hit_flag_fifo_afull_i,
    output logic                     hit_flag_fifo_wren_o,
    output logic                     hit_flag_fifo_wdata_o,
    input  logic                     hit_data_fifo_afull_i,
    output logic                     hit_data_fifo_wren_o,
    output logic [CC_HIT_DATA_W-1:0] hit_data_fifo_wdata_o,
    output logic [ADDR_WIDTH-1:0]    mem_araddr_o,
    output logic [3:0]               mem_arlen_o,
    output logic [2:0]               mem_arsize_o,
    output logic [1:0]               mem_arburst_o,
    output logic                     mem_arvalid_o,
    input  logic                     mem_arready_i,
    input  logic                     mem_rvalid_i,
    input  logic                     mem_rready_i,
    input  logic                     mem_rlast_i
);

    // Handshake: a lookup transfers on a cycle where lkup_valid_i & lkup_ready_o;
    // ready looks at the hit flag as payload but never at valid.
    logic ar_free;
    logic cnt_ok;
    logic accept;
    logic miss_accept;

    always_comb begin
        lkup_ready_o = 1'b0;
        if (rst_n) begin
            if (lkup_hit_i)
                lkup_ready_o = !hit_flag_fifo_afull_i & !hit_data_fifo_afull_i;
            else
                lkup_ready_o = !hit_flag_fifo_afull_i & ar_free & cnt_ok;
        end
    end

    assign accept      = lkup_valid_i & lkup_ready_o;
    assign miss_accept = accept & !lkup_hit_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_flag_fifo_wren_o  <= 1'b0;
            hit_flag_fifo_wdata_o <= 1'b0;
            hit_data_fifo_wren_o  <= 1'b0;
            hit_data_fifo_wdata_o <= '0;
        end else begin
            hit_flag_fifo_wren_o  <= accept;
            hit_flag_fifo_wdata_o <= accept & lkup_hit_i;
            hit_data_fifo_wren_o  <= accept & lkup_hit_i;
            if (accept && lkup_hit_i)
                hit_data_fifo_wdata_o <= {lkup_addr_i[CC_OFFSET_W-1:0], lkup_data_i};
        end
    end

    cc_miss_ar_issue #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_miss_ar (
        .clk         (clk),
        .rst_n       (rst_n),
        .miss_accept (miss_accept),
        .miss_addr   ({lkup_addr_i[ADDR_WIDTH-1:3], 3'b000}),
        .arready     (mem_arready_i),
        .rvalid      (mem_rvalid_i),
        .rready      (mem_rready_i),
        .rlast       (mem_rlast_i),
        .araddr      (mem_araddr_o),
        .arvalid     (mem_arvalid_o),
        .ar_free     (ar_free),
        .cnt_ok      (cnt_ok)
    );

    assign mem_arlen_o   = CC_AR_LEN;
    assign mem_arsize_o  = CC_AR_SIZE;
    assign mem_arburst_o = CC_AR_BURST_WRAP;

endmodule

// File: tb/tb_cc_lookup_dispatch.sv
// Directed bench for cc_lookup_dispatch with immediate-assertion checks.
module tb_cc_lookup_dispatch;
    import cc_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     lkup_valid;
    logic                     lkup_ready;
    logic                     lkup_hit;
    logic [31:0]              lkup_addr;
    logic [CC_LINE_W-1:0]     lkup_data;
    logic                     flag_afull;
    logic                     flag_wren;
    logic                     flag_wdata;
    logic                     data_afull;
    logic                     data_wren;
    logic [CC_HIT_DATA_W-1:0] data_wdata;
    logic [31:0]              araddr;
    logic [3:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic                     arvalid;
    logic                     arready;
    logic                     rvalid;
    logic                     rready;
    logic                     rlast;

    int n_checks = 0;
    int n_fail   = 0;
    int n_data_writes;
    logic [CC_LINE_W-1:0] line_aa;
    logic [CC_LINE_W-1:0] line_55;

    always #5 clk = ~clk;

    cc_lookup_dispatch #(.ADDR_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .lkup_valid_i          (lkup_valid),
        .lkup_ready_o          (lkup_ready),
        .lkup_hit_i            (lkup_hit),
        .lkup_addr_i           (lkup_addr),
        .lkup_data_i           (lkup_data),
        .hit_flag_fifo_afull_i (flag_afull),
        .hit_flag_fifo_wren_o  (flag_wren),
        .hit_flag_fifo_wdata_o (flag_wdata),
        .hit_data_fifo_afull_i (data_afull),
        .hit_data_fifo_wren_o  (data_wren),
        .hit_data_fifo_wdata_o (data_wdata),
        .mem_araddr_o          (araddr),
        .mem_arlen_o           (arlen),
        .mem_arsize_o          (arsize),
        .mem_arburst_o         (arburst),
        .mem_arvalid_o         (arvalid),
        .mem_arready_i         (arready),
        .mem_rvalid_i          (rvalid),
        .mem_rready_i          (rready),
        .mem_rlast_i           (rlast)
    );

    task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; returns 1 ns after it so registered outputs have settled.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic [31:0] a, input logic [CC_LINE_W-1:0] d);
        lkup_valid = v;
        lkup_hit   = h;
        lkup_addr  = a;
        lkup_data  = d;
        #1;
    endtask

    task automatic rlast_beat(input logic on);
        rvalid = on;
        rready = on;
        rlast  = on;
    endtask

    initial begin
        line_aa = {64{8'hAA}};
        line_55 = {64{8'h55}};
        rst_n = 1'b0;
        flag_afull = 1'b0;
        data_afull = 1'b0;
        arready = 1'b0;
        rlast_beat(1'b0);
        drive(1'b1, 1'b1, 32'h0, '0);

        // Reset state
        cyc();
        cyc();
        chk("rst_ready", lkup_ready, 1'b0);
        chk("rst_flag_wren", flag_wren, 1'b0);
        chk("rst_data_wren", data_wren, 1'b0);
        chk("rst_data_wdata", data_wdata, '0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_miss_cnt", dut.u_miss_ar.miss_cnt, 3'd0);
        chk("rst_state", dut.u_miss_ar.state, AR_IDLE);
        rst_n = 1'b1;

        // Single hit
        drive(1'b1, 1'b1, 32'h0000_1028, line_aa);
        chk("hit_ready", lkup_ready, 1'b1);
        cyc();
        chk("hit_flag_wren", flag_wren, 1'b1);
        chk("hit_flag_wdata", flag_wdata, 1'b1);
        chk("hit_data_wren", data_wren, 1'b1);
        chk("hit_data_wdata", data_wdata, {6'h28, line_aa});
        chk("hit_arvalid", arvalid, 1'b0);
        drive(1'b0, 1'b0, 32'h0, '0);
        cyc();
        chk("idle_flag_wren", flag_wren, 1'b0);
        chk("idle_data_wren", data_wren, 1'b0);

        // Single miss with arready high
        arready = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_2034, '0);
        chk("miss_ready", lkup_ready, 1'b1);
        cyc();
        chk("miss_flag_wren", flag_wren, 1'b1);
        chk("miss_flag_wdata", flag_wdata, 1'b0);
        chk("miss_data_wren", data_wren, 1'b0);
        chk("miss_arvalid", arvalid, 1'b1);
        chk("miss_araddr", araddr, 32'h0000_2030);
        chk("miss_arlen", arlen, 4'd7);
        chk("miss_arsize", arsize, 3'b011);
        chk("miss_arburst", arburst, 2'b10);
        chk("miss_cnt1", dut.u_miss_ar.miss_cnt, 3'd1);
        drive(1'b0, 1'b0, 32'h0, '0);
        cyc();
        chk("miss_ar_done", arvalid, 1'b0);

        // hit, miss, hit, miss back to back
        n_data_writes = 0;
        drive(1'b1, 1'b1, 32'h0000_0040, line_55);
        cyc();
        chk("seq0_flag", {flag_wren, flag_wdata}, 2'b11);
        n_data_writes += int'(data_wren);
        drive(1'b1, 1'b0, 32'h0000_0100, '0);
        cyc();
        chk("seq1_flag", {flag_wren, flag_wdata}, 2'b10);
        n_data_writes += int'(data_wren);
        drive(1'b1, 1'b1, 32'h0000_0080, line_aa);
        cyc();
        chk("seq2_flag", {flag_wren, flag_wdata}, 2'b11);
        n_data_writes += int'(data_wren);
        drive(1'b1, 1'b0, 32'h0000_0207, '0);
        cyc();
        chk("seq3_flag", {flag_wren, flag_wdata}, 2'b10);
        chk("seq3_araddr", araddr, 32'h0000_0200);
        n_data_writes += int'(data_wren);
        drive(1'b0, 1'b0, 32'h0, '0);
        cyc();
        n_data_writes += int'(data_wren);
        chk("seq_data_writes", n_data_writes, 2);
        chk("seq_miss_cnt", dut.u_miss_ar.miss_cnt, 3'd3);
        chk("seq_ar_done", arvalid, 1'b0);

        // Drain outstanding misses
        rlast_beat(1'b1);
        cyc();
        cyc();
        cyc();
        rlast_beat(1'b0);
        chk("drain_cnt0", dut.u_miss_ar.miss_cnt, 3'd0);

        // Outstanding limit: four accepted, fifth held until one rlast beat
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0000_3000 + 32'(i) * 32'h40 + 32'h0D, '0);
            chk("lim_ready", lkup_ready, 1'b1);
            cyc();
            chk("lim_araddr", araddr, 32'h0000_3008 + 32'(i) * 32'h40);
        end
        chk("lim_cnt4", dut.u_miss_ar.miss_cnt, 3'd4);
        drive(1'b1, 1'b0, 32'h0000_3111, '0);
        chk("lim_5th_held", lkup_ready, 1'b0);
        cyc();
        chk("lim_5th_no_wren", flag_wren, 1'b0);
        rlast_beat(1'b1);
        #1;
        chk("lim_rlast_cycle_ready", lkup_ready, 1'b0);
        cyc();
        rlast_beat(1'b0);
        #1;
        chk("lim_after_rlast_ready", lkup_ready, 1'b1);
        cyc();
        chk("lim_5th_flag", {flag_wren, flag_wdata}, 2'b10);
        chk("lim_5th_araddr", araddr, 32'h0000_3110);
        chk("lim_5th_cnt", dut.u_miss_ar.miss_cnt, 3'd4);
        drive(1'b0, 1'b0, 32'h0, '0);
        cyc();
        rlast_beat(1'b1);
        cyc();
        cyc();
        cyc();
        cyc();
        rlast_beat(1'b0);
        chk("lim_drain_cnt0", dut.u_miss_ar.miss_cnt, 3'd0);

        // AR back-pressure: address held, second miss waits for arready
        arready = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_4444, '0);
        cyc();
        chk("bp_arvalid", arvalid, 1'b1);
        chk("bp_araddr", araddr, 32'h0000_4440);
        drive(1'b1, 1'b0, 32'h0000_5555, '0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_second_blocked", lkup_ready, 1'b0);
            cyc();
            chk("bp_hold_arvalid", arvalid, 1'b1);
            chk("bp_hold_araddr", araddr, 32'h0000_4440);
            chk("bp_no_wren", flag_wren, 1'b0);
        end
        arready = 1'b1;
        #1;
        chk("bp_second_ready", lkup_ready, 1'b1);
        cyc();
        chk("bp_second_flag", {flag_wren, flag_wdata}, 2'b10);
        chk("bp_second_arvalid", arvalid, 1'b1);
        chk("bp_second_araddr", araddr, 32'h0000_5550);
        chk("bp_state", dut.u_miss_ar.state, AR_VALID);
        chk("bp_cnt2", dut.u_miss_ar.miss_cnt, 3'd2);

        // FIFO almost-full gating, then reset with AR pending
        arready = 1'b0;
        data_afull = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_0A00, line_aa);
        chk("afull_hit_ready", lkup_ready, 1'b0);
        cyc();
        chk("afull_no_flag", flag_wren, 1'b0);
        chk("afull_no_data", data_wren, 1'b0);
        arready = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_6666, '0);
        chk("afull_miss_ready", lkup_ready, 1'b1);
        cyc();
        chk("afull_miss_flag", {flag_wren, flag_wdata}, 2'b10);
        chk("afull_miss_araddr", araddr, 32'h0000_6660);
        arready = 1'b0;
        data_afull = 1'b0;
        flag_afull = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_0A00, line_aa);
        chk("flag_afull_hit_ready", lkup_ready, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0A00, '0);
        chk("flag_afull_miss_ready", lkup_ready, 1'b0);
        cyc();
        chk("flag_afull_no_wren", flag_wren, 1'b0);
        chk("pre_rst_arvalid", arvalid, 1'b1);
        flag_afull = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", lkup_ready, 1'b0);
        cyc();
        chk("midrst_arvalid", arvalid, 1'b0);
        chk("midrst_cnt", dut.u_miss_ar.miss_cnt, 3'd0);
        chk("midrst_flag_wren", flag_wren, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, '0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
